// File: rtl/pwm_deadtime_gen_pkg.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen_pkg
// Shared definitions for the PWM dead-time generator:
//   PWM_DT_BITS_DEFAULT : default dead-band counter width. The carrier
//                         generator configuration uses the same value.
//   state_e             : FSM state encoding (3-bit).
// -----------------------------------------------------------------------------
package pwm_deadtime_gen_pkg;

  localparam int PWM_DT_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DT_TO_H = 3'd1,
    ST_HIGH    = 3'd2,
    ST_DT_TO_L = 3'd3,
    ST_LOW     = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

endpackage : pwm_deadtime_gen_pkg

// File: rtl/pwm_deadtime_gen_if.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen_if
// Control and gate-drive bundle of the dead-time generator.
//   En         : 1 = drive outputs, 0 = both outputs off
//   PwmIn      : registered single-ended PWM from the comparator
//   DeadTime   : dead-band length in Clk cycles (0 = no dead band)
//   Fault      : fault request, level, highest priority
//   FaultClr   : clears the latched fault once Fault is low
//   OutH/OutL  : complementary high-/low-side gate drive
//   FaultLatch : 1 while the generator is held in fault shutdown
// Modports: master = stimulus/controller side, slave = generator side.
// -----------------------------------------------------------------------------
interface pwm_deadtime_gen_if
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DT_BITS = PWM_DT_BITS_DEFAULT
);

  logic               En;
  logic               PwmIn;
  logic [DT_BITS-1:0] DeadTime;
  logic               Fault;
  logic               FaultClr;
  logic               OutH;
  logic               OutL;
  logic               FaultLatch;

  modport master (
    output En, PwmIn, DeadTime, Fault, FaultClr,
    input  OutH, OutL, FaultLatch
  );

  modport slave (
    input  En, PwmIn, DeadTime, Fault, FaultClr,
    output OutH, OutL, FaultLatch
  );

endinterface : pwm_deadtime_gen_if

// File: rtl/pwm_deadband_counter.sv
// -----------------------------------------------------------------------------
// pwm_deadband_counter
// Down-counter timing one dead band.
//   Clk     : clock
//   Rst     : asynchronous reset, active-low (count -> 0)
//   Load    : load LoadVal (has priority over Dec)
//   LoadVal : value loaded on Load
//   Dec     : decrement by one
//   Zero    : count == 0 (combinational from the count register)
// -----------------------------------------------------------------------------
module pwm_deadband_counter
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DT_BITS = PWM_DT_BITS_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Load,
  input  logic [DT_BITS-1:0] LoadVal,
  input  logic               Dec,
  output logic               Zero
);

  logic [DT_BITS-1:0] r_count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of every other flop.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (Load) begin
      r_count <= LoadVal;
    end else if (Dec) begin
      r_count <= r_count - DT_BITS'(1);
    end
  end

  assign Zero = (r_count == '0);

endmodule : pwm_deadband_counter

// File: rtl/pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// pwm_deadtime_gen
// Turns a single-ended PWM stream into a complementary high/low gate-drive
// pair with a programmable dead band at every edge, plus enable and a
// latched fault shutdown. Last digital stage before the power-stage pins.
//   Clk : system clock
//   Rst : asynchronous reset, active-low
//   io  : pwm_deadtime_gen_if.slave (En, PwmIn, DeadTime, Fault, FaultClr in;
//         OutH, OutL, FaultLatch out, all outputs registered)
// Outputs are decoded from the next state and registered at the same edge as
// the state, so OutH/OutL are mutually exclusive by construction.
// -----------------------------------------------------------------------------
module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DT_BITS = PWM_DT_BITS_DEFAULT
) (
  input  logic                Clk,
  input  logic                Rst,
  pwm_deadtime_gen_if.slave   io
);

  state_e             r_state;
  state_e             w_next;
  logic               r_out_h;
  logic               r_out_l;
  logic               r_fault_latch;

  logic               w_load;
  logic               w_dec;
  logic               w_zero;
  logic               w_go_h;
  logic               w_go_l;
  logic               w_dt_zero;
  logic [DT_BITS-1:0] w_load_val;

  assign w_dt_zero  = (io.DeadTime == '0);
  // The band lasts DeadTime edges: the entry edge plus DeadTime-1 counts.
  assign w_load_val = io.DeadTime - DT_BITS'(1);

  pwm_deadband_counter #(
    .DT_BITS (DT_BITS)
  ) u_counter (
    .Clk     (Clk),
    .Rst     (Rst),
    .Load    (w_load),
    .LoadVal (w_load_val),
    .Dec     (w_dec),
    .Zero    (w_zero)
  );

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_go_h = 1'b0;
    w_go_l = 1'b0;

    if (io.Fault) begin
      w_next = ST_FAULT;
    end else if (r_state == ST_FAULT) begin
      // Fault is already known low on this path.
      if (io.FaultClr) w_next = ST_IDLE;
    end else if (!io.En) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (io.PwmIn) w_go_h = 1'b1;
          else          w_go_l = 1'b1;
        end
        ST_LOW: begin
          if (io.PwmIn) w_go_h = 1'b1;
        end
        ST_HIGH: begin
          if (!io.PwmIn) w_go_l = 1'b1;
        end
        ST_DT_TO_H: begin
          // Aborting back to LOW is safe: OutH was never asserted.
          if (!io.PwmIn)   w_next = ST_LOW;
          else if (w_zero) w_next = ST_HIGH;
          else             w_dec  = 1'b1;
        end
        ST_DT_TO_L: begin
          if (io.PwmIn)    w_next = ST_HIGH;
          else if (w_zero) w_next = ST_LOW;
          else             w_dec  = 1'b1;
        end
        default: w_next = ST_IDLE;
      endcase

      // A zero dead band skips the dead state and switches on the same edge.
      if (w_go_h) begin
        w_next = w_dt_zero ? ST_HIGH : ST_DT_TO_H;
        w_load = !w_dt_zero;
      end else if (w_go_l) begin
        w_next = w_dt_zero ? ST_LOW : ST_DT_TO_L;
        w_load = !w_dt_zero;
      end
    end
  end

  // NOTE: only control/state flops exist here and all take the async reset;
  // the fault latch is deliberately lost on reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= ST_IDLE;
      r_out_h       <= 1'b0;
      r_out_l       <= 1'b0;
      r_fault_latch <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_out_h       <= (w_next == ST_HIGH);
      r_out_l       <= (w_next == ST_LOW);
      r_fault_latch <= (w_next == ST_FAULT);
    end
  end

  assign io.OutH       = r_out_h;
  assign io.OutL       = r_out_l;
  assign io.FaultLatch = r_fault_latch;

endmodule : pwm_deadtime_gen

// File: tb/tb_pwm_deadtime_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime_gen
// Directed scenarios followed by randomized stimulus, all compared each cycle
// against a behavioural model of the gate-drive outputs.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

  localparam int DT_BITS = 8;

  logic Clk;
  logic Rst;

  pwm_deadtime_gen_if #(.DT_BITS(DT_BITS)) bus ();

  pwm_deadtime_gen #(.DT_BITS(DT_BITS)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .io  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_target is the level the bridge is driving or heading to
  // (-1 = nothing), m_wait the dead-band edges still to elapse before that
  // level is driven, m_fault the latched shutdown.
  // ---------------------------------------------------------------------------
  int m_target;
  int m_wait;
  bit m_fault;

  function automatic void model_reset();
    m_target = -1;
    m_wait   = 0;
    m_fault  = 1'b0;
  endfunction

  function automatic void model_edge(input bit en, input bit pwm, input int dt,
                                     input bit f, input bit fc);
    if (f) begin
      m_fault  = 1'b1;
      m_target = -1;
      m_wait   = 0;
    end else if (m_fault) begin
      if (fc) m_fault = 1'b0;
    end else if (!en) begin
      m_target = -1;
      m_wait   = 0;
    end else if (m_target < 0) begin
      m_target = int'(pwm);
      m_wait   = dt;
    end else if (int'(pwm) != m_target) begin
      if (m_wait > 0) begin
        m_target = int'(pwm);   // swallowed short pulse/gap
        m_wait   = 0;
      end else begin
        m_target = int'(pwm);
        m_wait   = dt;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end
  endfunction

  task automatic check_outputs(input string tag);
    bit exp_h, exp_l;
    exp_h = !m_fault && m_target == 1 && m_wait == 0;
    exp_l = !m_fault && m_target == 0 && m_wait == 0;
    check({tag, ".OutH"},       32'(bus.OutH),        32'(exp_h));
    check({tag, ".OutL"},       32'(bus.OutL),        32'(exp_l));
    check({tag, ".FaultLatch"}, 32'(bus.FaultLatch),  32'(m_fault));
    check({tag, ".excl"},       32'(bus.OutH & bus.OutL), 32'(0));
  endtask

  // Inputs are driven at the falling edge, the model advances for the coming
  // rising edge, outputs are checked at the next falling edge.
  task automatic step(input string tag, input bit en, input bit pwm, input int dt,
                      input bit f, input bit fc);
    bus.En       = en;
    bus.PwmIn    = pwm;
    bus.DeadTime = DT_BITS'(dt);
    bus.Fault    = f;
    bus.FaultClr = fc;
    model_edge(en, pwm, dt, f, fc);
    @(posedge Clk);
    @(negedge Clk);
    check_outputs(tag);
  endtask

  task automatic repeat_step(input string tag, input int n, input bit en, input bit pwm,
                             input int dt, input bit f, input bit fc);
    for (int i = 0; i < n; i++) step(tag, en, pwm, dt, f, fc);
  endtask

  // Reset is asserted between edges to check that it acts asynchronously.
  task automatic reset_pulse(input int cycles);
    @(negedge Clk);
    #2;
    Rst = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    for (int i = 0; i < cycles; i++) begin
      bus.PwmIn = ~bus.PwmIn;
      bus.En    = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      check_outputs("rst_hold");
    end
    Rst = 1'b1;
  endtask

  int run_left;
  int fault_left;
  int en_off_left;
  bit r_pwm;
  int r_dt;

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    Rst          = 1'b1;
    bus.En       = 1'b0;
    bus.PwmIn    = 1'b0;
    bus.DeadTime = '0;
    bus.Fault    = 1'b0;
    bus.FaultClr = 1'b0;

    // 1. Reset with PwmIn toggling, then first band from IDLE with DeadTime=4.
    reset_pulse(4);
    repeat_step("t1_start", 7, 1'b1, 1'b0, 4, 1'b0, 1'b0);

    // 2. Normal edges with DeadTime=3.
    repeat_step("t2_rise", 6, 1'b1, 1'b1, 3, 1'b0, 1'b0);
    repeat_step("t2_fall", 6, 1'b1, 1'b0, 3, 1'b0, 1'b0);

    // 3. Zero dead band, PwmIn toggling every 5 cycles.
    for (int k = 0; k < 6; k++)
      repeat_step("t3_dt0", 5, 1'b1, k[0], 0, 1'b0, 1'b0);

    // 4. Short 4-cycle pulse against DeadTime=6 is swallowed.
    repeat_step("t4_low",   10, 1'b1, 1'b0, 6, 1'b0, 1'b0);
    repeat_step("t4_pulse",  4, 1'b1, 1'b1, 6, 1'b0, 1'b0);
    repeat_step("t4_back",   8, 1'b1, 1'b0, 6, 1'b0, 1'b0);

    // 5. Fault from HIGH, clear blocked while Fault=1, then clear and resume.
    repeat_step("t5_high",  6, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    step       ("t5_fault",    1'b1, 1'b1, 2, 1'b1, 1'b0);
    step       ("t5_clr_blk",  1'b1, 1'b1, 2, 1'b1, 1'b1);
    repeat_step("t5_hold",  3, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    step       ("t5_clr",      1'b1, 1'b1, 2, 1'b0, 1'b1);
    repeat_step("t5_resume", 6, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    // 6. DeadTime changes 8->2 inside a band: current band keeps 8.
    repeat_step("t6_low", 12, 1'b1, 1'b0, 8, 1'b0, 1'b0);
    step       ("t6_rise",    1'b1, 1'b1, 8, 1'b0, 1'b0);
    repeat_step("t6_band", 10, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    repeat_step("t6_next",  5, 1'b1, 1'b0, 2, 1'b0, 1'b0);

    // Enable drop and re-entry.
    repeat_step("en_off", 3, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    repeat_step("en_on",  5, 1'b1, 1'b1, 2, 1'b0, 1'b0);

    // Randomized phase.
    r_pwm       = 1'b0;
    r_dt        = 3;
    run_left    = 0;
    fault_left  = 0;
    en_off_left = 0;
    for (int c = 0; c < 4000; c++) begin
      bit f, fc, en;
      if (c == 2000) reset_pulse(3);
      if (run_left == 0) begin
        r_pwm    = ~r_pwm;
        run_left = int'($urandom_range(1, 14));
      end
      run_left--;
      if ($urandom_range(0, 19) == 0) r_dt = int'($urandom_range(0, 9));
      if (fault_left == 0 && $urandom_range(0, 249) == 0)
        fault_left = int'($urandom_range(1, 3));
      if (en_off_left == 0 && $urandom_range(0, 149) == 0)
        en_off_left = int'($urandom_range(1, 5));
      f  = (fault_left > 0);
      en = (en_off_left == 0);
      fc = ($urandom_range(0, 3) == 0);
      if (fault_left > 0)  fault_left--;
      if (en_off_left > 0) en_off_left--;
      step("rand", en, r_pwm, r_dt, f, fc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pwm_deadtime_gen
